id_hazard_stall_controller: RTL and testbench
=============================================

Name: id_hazard_stall_controller

Overview:
- ID-stage scheduler for the 5-stage MIPS pipeline. It sits beside the decode datapath (register file, sign extender, branch comparator).
- It decides each cycle whether the instruction in ID may advance, or whether IF/ID must hold and a bubble must be injected into ID/EX.
- It also owns the multi-cycle MULT/DIV unit's occupancy (issue pulse and busy counter) and keeps a stall-cycle performance counter.

Parameters:
- MULDIV_LATENCY, 32: cycles the mult/div unit stays busy after issue; must be >= 1.
- CNT_W, 6: width of the busy counter; must satisfy 2^CNT_W > MULDIV_LATENCY.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_flush  in  1  ID instruction is being squashed this cycle.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  BEQ/BNE; compared in ID.
- id_is_muldiv  in  1  MULT/MULTU/DIV/DIVU.
- id_reads_hilo  in  1  MFHI/MFLO.
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_rd  in  5  EX destination register.
- mem_mem_read  in  1  MEM instruction is a load.
- mem_rd  in  5  MEM destination register.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- idex_bubble  out  1  zero the control bits entering ID/EX.
- muldiv_start  out  1  one-cycle issue pulse to the mult/div unit.
- muldiv_busy  out  1  mult/div unit occupied.
- stall_count  out  32  number of stall cycles since reset.

Behaviour:
- Effective ID instruction: act = id_valid & ~id_flush. When act=0, no hazard is raised and no issue occurs.
- Operand match against register R: m(R) = R!=0 & ((id_uses_rs & id_rs==R) | (id_uses_rt & id_rt==R)). Register $0 never matches.
- load_use = act & ex_mem_read & m(ex_rd).
- br_ex = act & id_is_branch & ex_reg_write & m(ex_rd). Covers ALU results and loads in EX.
- br_mem = act & id_is_branch & mem_mem_read & m(mem_rd). Load data is not yet forwardable to the ID comparator.
- md_hold = act & (id_is_muldiv | id_reads_hilo) & muldiv_busy.
- stall = load_use | br_ex | br_mem | md_hold.
- Stall outputs are combinational, same cycle, no latency:
  - pc_write = ifid_write = ~stall
  - idex_bubble = stall
- muldiv_start = act & id_is_muldiv & ~stall. It is never asserted while muldiv_busy=1.
- Mult/div state machine, states IDLE and BUSY:
  - IDLE: if muldiv_start, go to BUSY with cnt = MULDIV_LATENCY-1; otherwise stay.
  - BUSY: if cnt==0, go to IDLE; otherwise cnt = cnt-1.
  - muldiv_busy = (state==BUSY).
  - Timing: an issue in cycle T gives busy=1 for cycles T+1 .. T+MULDIV_LATENCY. An MFHI held in ID proceeds in cycle T+MULDIV_LATENCY+1.
  - MULDIV_LATENCY=1 gives exactly one busy cycle.
- A branch that is itself the consumer of a load in EX raises both load_use and br_ex. This is one stall cycle; the next cycle is re-evaluated from fresh inputs. A load in EX followed by a dependent branch therefore stalls 2 cycles in total (EX, then MEM).
- stall_count increments by 1 at every edge where stall=1. It wraps from 0xFFFFFFFF to 0.
- Reset (synchronous):
  - At the edge: state=IDLE, cnt=0, stall_count=0.
  - While reset=1, outputs are forced regardless of inputs: pc_write=1, ifid_write=1, idex_bubble=0, muldiv_start=0.
  - Reset during BUSY aborts the operation; muldiv_busy=0 on the cycle after the reset edge.
- Simultaneous id_flush and hazard: the flush wins, so no stall and no issue.

Decomposition:
- Shared package/header:
  - state encodings IDLE=1'b0, BUSY=1'b1
  - REG_ZERO=5'd0
  - default MULDIV_LATENCY
- One natural sub-module: muldiv_busy_counter. It holds the state, the down-counter and the busy output, and takes start, clock and reset.
- Hazard equations and stall_count stay in the top module.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=8, ID uses rs=8 → stall 1 cycle (pc_write=0, idex_bubble=1). Next cycle with ex_mem_read=0 → no stall; stall_count=1.
2. Register $0: ex_mem_read=1, ex_rd=0, ID uses rs=0 → no stall.
3. Branch after load: BEQ on rt=9 with a load to rd 9 in EX, then in MEM → stall 2 consecutive cycles. An ALU write to rd 9 in EX with nothing in MEM → stall exactly 1 cycle.
4. MULDIV_LATENCY=4: MULT issued at T (muldiv_start=1 for one cycle). MFLO in ID from T+1 → stalled T+1..T+4, advances at T+5, muldiv_busy=0 at T+5. A second MULT at T+2 → stalled, no start pulse.
5. Flush override: load_use conditions true with id_flush=1 → pc_write=1, idex_bubble=0. id_is_muldiv=1 with flush → muldiv_start=0.
6. Reset during BUSY: assert reset at T+2 of a 32-cycle operation → next cycle muldiv_busy=0, stall_count=0. While reset is held, pc_write=1 and muldiv_start=0 even with hazard inputs set.

Source files
------------

// File: rtl/id_hazard_stall_controller_pkg.sv
// Shared definitions for the ID-stage hazard/stall controller and its
// mult/div occupancy tracker.
package id_hazard_stall_controller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO           = 5'd0;
  localparam int         MULDIV_LATENCY_DEF = 32;

  // True when the ID instruction reads register r; $0 never produces a dependence.
  function automatic logic reg_match(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rs,
    input logic       uses_rt,
    input logic [4:0] r
  );
    return (r != REG_ZERO) && ((uses_rs && (rs == r)) || (uses_rt && (rt == r)));
  endfunction

endpackage

// File: rtl/id_hazard_stall_controller_busy.sv
// Mult/div occupancy: a start pulse keeps busy high for MULDIV_LATENCY cycles.
module muldiv_busy_counter
  import id_hazard_stall_controller_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEF,
  parameter int CNT_W          = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = BUSY;
        cnt_d   = CNT_LOAD;
      end
      BUSY: if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/id_hazard_stall_controller.sv
// ID-stage scheduler: load-use / branch-operand / mult-div hazards, stall
// enables, mult/div issue and a stall-cycle counter.
module id_hazard_stall_controller
  import id_hazard_stall_controller_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEF,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_flush,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_branch,
  input  logic        id_is_muldiv,
  input  logic        id_reads_hilo,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        muldiv_start,
  output logic        muldiv_busy,
  output logic [31:0] stall_count
);

  logic        act, m_ex, m_mem;
  logic        load_use, br_ex, br_mem, md_hold;
  logic        stall;
  logic [31:0] stall_count_q;

  assign act   = id_valid & ~id_flush;
  assign m_ex  = reg_match(id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd);
  assign m_mem = reg_match(id_rs, id_rt, id_uses_rs, id_uses_rt, mem_rd);

  // Branch operands are compared in ID, so any EX producer and a MEM load
  // are both still out of reach of the comparator's forwarding.
  assign load_use = act & ex_mem_read & m_ex;
  assign br_ex    = act & id_is_branch & ex_reg_write & m_ex;
  assign br_mem   = act & id_is_branch & mem_mem_read & m_mem;
  assign md_hold  = act & (id_is_muldiv | id_reads_hilo) & muldiv_busy;

  assign stall = ~reset & (load_use | br_ex | br_mem | md_hold);

  assign pc_write     = ~stall;
  assign ifid_write   = ~stall;
  assign idex_bubble  = stall;
  assign muldiv_start = ~reset & act & id_is_muldiv & ~stall;

  muldiv_busy_counter #(
    .MULDIV_LATENCY (MULDIV_LATENCY),
    .CNT_W          (CNT_W)
  ) u_busy (
    .clock (clock),
    .reset (reset),
    .start (muldiv_start),
    .busy  (muldiv_busy)
  );

  always_ff @(posedge clock) begin
    if (reset)      stall_count_q <= '0;
    else if (stall) stall_count_q <= stall_count_q + 32'd1;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_hazard_stall_controller.sv
// Bench for id_hazard_stall_controller: directed test-plan steps followed by
// random traffic, all checked against a cycle-indexed reference model.
module tb_id_hazard_stall_controller;

  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid, id_flush;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt, id_is_branch, id_is_muldiv, id_reads_hilo;
  logic        ex_mem_read, ex_reg_write;
  logic [4:0]  ex_rd;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;
  logic        pc_write, ifid_write, idex_bubble, muldiv_start, muldiv_busy;
  logic [31:0] stall_count;

  int checks   = 0;
  int failures = 0;

  // Reference state: current cycle index, last cycle the unit is busy, stall tally.
  longint      cyc;
  longint      busy_end;
  logic [31:0] sc;

  always #5 clock = ~clock;

  id_hazard_stall_controller #(.MULDIV_LATENCY(LAT), .CNT_W(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_flush      (id_flush),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_is_branch  (id_is_branch),
    .id_is_muldiv  (id_is_muldiv),
    .id_reads_hilo (id_reads_hilo),
    .ex_mem_read   (ex_mem_read),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .mem_mem_read  (mem_mem_read),
    .mem_rd        (mem_rd),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .idex_bubble   (idex_bubble),
    .muldiv_start  (muldiv_start),
    .muldiv_busy   (muldiv_busy),
    .stall_count   (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic reads(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r);
  endfunction

  function automatic logic model_hazard(input logic busy);
    logic act;
    act = id_valid && !id_flush;
    if (!act) return 1'b0;
    if (ex_mem_read && reads(ex_rd)) return 1'b1;
    if (id_is_branch && ex_reg_write && reads(ex_rd)) return 1'b1;
    if (id_is_branch && mem_mem_read && reads(mem_rd)) return 1'b1;
    if ((id_is_muldiv || id_reads_hilo) && busy) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    reset = 0; id_valid = 0; id_flush = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0; id_is_muldiv = 0; id_reads_hilo = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; mem_mem_read = 0; mem_rd = 0;
  endtask

  // One clock cycle: predict, compare at the falling edge, then advance the model.
  task automatic step();
    logic e_busy, hz, e_pc, e_bub, e_st;
    e_busy = (cyc <= busy_end);
    hz     = model_hazard(e_busy);
    if (reset) begin
      e_pc = 1'b1; e_bub = 1'b0; e_st = 1'b0;
    end else begin
      e_pc = !hz; e_bub = hz; e_st = id_valid && !id_flush && id_is_muldiv && !hz;
    end
    @(negedge clock);
    chk("pc_write",     {31'd0, pc_write},     {31'd0, e_pc});
    chk("ifid_write",   {31'd0, ifid_write},   {31'd0, e_pc});
    chk("idex_bubble",  {31'd0, idex_bubble},  {31'd0, e_bub});
    chk("muldiv_start", {31'd0, muldiv_start}, {31'd0, e_st});
    chk("muldiv_busy",  {31'd0, muldiv_busy},  {31'd0, e_busy});
    chk("stall_count",  stall_count,           sc);
    @(posedge clock);
    if (reset) begin
      busy_end = -1;
      sc       = 32'd0;
    end else begin
      if (!e_pc) sc = sc + 32'd1;
      if (e_st)  busy_end = cyc + LAT;
    end
    cyc++;
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    cyc = 0; busy_end = -1; sc = 0;
    @(posedge clock); #1;
    reset = 0;
    step();
    chk("reset_count", stall_count, 32'd0);

    // Load-use on rs=8, then the load has moved on.
    id_valid = 1; id_uses_rs = 1; id_rs = 8; ex_mem_read = 1; ex_rd = 8;
    step();
    ex_mem_read = 0;
    step();
    chk("t1_count", stall_count, 32'd1);

    // $0 never creates a dependence.
    ex_mem_read = 1; ex_rd = 0; id_rs = 0;
    step();
    chk("t2_count", stall_count, 32'd1);

    // Branch on rt=9 behind a load: EX then MEM stage stalls.
    clear_inputs();
    id_valid = 1; id_is_branch = 1; id_uses_rt = 1; id_rt = 9;
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9;
    step();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; mem_mem_read = 1; mem_rd = 9;
    step();
    mem_mem_read = 0; mem_rd = 0;
    step();
    chk("t3_count", stall_count, 32'd3);
    ex_reg_write = 1; ex_rd = 9;
    step();
    ex_reg_write = 0;
    step();
    chk("t3_alu_count", stall_count, 32'd4);

    // MULT at T, MFLO waits T+1..T+4; a second MULT at T+2 is held too.
    clear_inputs();
    id_valid = 1; id_is_muldiv = 1;
    step();
    id_is_muldiv = 0; id_reads_hilo = 1;
    step();
    id_reads_hilo = 0; id_is_muldiv = 1;
    step();
    id_is_muldiv = 0; id_reads_hilo = 1;
    repeat (3) step();
    chk("t4_count", stall_count, 32'd8);

    // Flush overrides every hazard and any issue.
    clear_inputs();
    id_valid = 1; id_flush = 1; id_uses_rs = 1; id_rs = 8; ex_mem_read = 1; ex_rd = 8;
    id_is_muldiv = 1;
    step();
    chk("t5_count", stall_count, 32'd8);

    // Reset two cycles into a 4-cycle operation, with hazards present.
    clear_inputs();
    id_valid = 1; id_is_muldiv = 1;
    step();
    id_is_muldiv = 0;
    step();
    reset = 1; id_reads_hilo = 1; id_is_muldiv = 1; id_uses_rs = 1; id_rs = 3;
    ex_mem_read = 1; ex_rd = 3;
    step();
    clear_inputs();
    step();
    chk("t6_busy",  {31'd0, muldiv_busy}, 32'd0);
    chk("t6_count", stall_count, 32'd0);

    // Random traffic over a narrow register range so dependences are frequent.
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 39) == 0);
      id_valid      = ($urandom_range(0, 9) != 0);
      id_flush      = ($urandom_range(0, 7) == 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom);
      id_uses_rt    = 1'($urandom);
      id_is_branch  = ($urandom_range(0, 3) == 0);
      id_is_muldiv  = ($urandom_range(0, 4) == 0);
      id_reads_hilo = ($urandom_range(0, 4) == 0);
      ex_mem_read   = 1'($urandom);
      ex_reg_write  = 1'($urandom);
      ex_rd         = 5'($urandom_range(0, 3));
      mem_mem_read  = 1'($urandom);
      mem_rd        = 5'($urandom_range(0, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
